m_mux_rr: RTL

- Parametrised successor to the team's 2:1 combinational mux: N-channel, W-bit registered multiplexer with per-channel valid/ready handshake and built-in arbitration.
- Selects one requesting channel per cycle, using round-robin or fixed-priority arbitration chosen at run time.
- Forwards the granted word through a single output register with backpressure.
- Sits between several producer blocks and one shared consumer, for example a shared bus or display path.

---
 rtl/m_mux_rr_pkg.sv | 10 +
 rtl/m_rr_arbiter.sv | 41 ++++
 rtl/m_mux_rr.sv | 71 +++++++
 3 files changed

// File: rtl/m_mux_rr_pkg.sv
// rtl/m_mux_rr_pkg.sv - shared constants for the round-robin registered mux
package m_mux_rr_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

endpackage

// File: rtl/m_rr_arbiter.sv
// rtl/m_rr_arbiter.sv - combinational round-robin / fixed-priority arbiter
module m_rr_arbiter
    import m_mux_rr_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            mode,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx
);

    logic            found;
    logic [SELW-1:0] idx;
    int              sum;

    // Scan order starts at ptr in round-robin mode and at 0 in fixed mode;
    // the explicit subtract keeps the wrap correct for non-power-of-two N.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        sum       = 0;
        for (int k = 0; k < N; k++) begin
            sum = (mode == MODE_FIXED) ? k : int'(ptr) + k;
            if (sum >= N) begin
                sum = sum - N;
            end
            idx = SELW'(sum);
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
        grant = (found && en) ? (N'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/m_mux_rr.sv
// rtl/m_mux_rr.sv - N-channel registered mux with valid/ready and run-time arbitration
module m_mux_rr
    import m_mux_rr_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int W    = DEF_W,
    parameter int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    input  logic              mode,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_sel,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] grant_idx;
    logic [N-1:0]    grant;
    logic            can_load;
    logic [W-1:0]    sel_word;

    assign can_load = ~out_valid | out_ready;

    m_rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .mode      (mode),
        .en        (can_load & ~rst),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign in_ready = grant;

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N; i++) begin
            if (SELW'(i) == grant_idx) begin
                sel_word = in_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (|grant) begin
            out_valid <= 1'b1;
            out_data  <= sel_word;
            out_sel   <= grant_idx;
            if (mode == MODE_RR) begin
                ptr <= (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
            end
        end else if (out_ready) begin
            // Drain with nothing to reload: keep the last word/index visible.
            out_valid <= 1'b0;
        end
    end

endmodule
